// File: rtl/decode_ctrl_if.sv
// Bundle of the job-control, pixel-memory, extractor and payload-sink signals
// around decode_ctrl. The controller connects as master, its environment as slave.
interface decode_ctrl_if;
    // job control
    logic        start;
    logic [15:0] base_addr;
    logic        busy;
    logic        finish;
    logic        err;
    // pixel memory read port
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    // LSB extractor
    logic        dec_load;
    logic [7:0]  dec_byte;
    logic        dec_done;
    logic [7:0]  dec_result;
    // payload stream to the sink
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        input  start, base_addr, mem_ack, mem_data, dec_done, dec_result, out_ready,
        output busy, finish, err, mem_req, mem_addr, dec_load, dec_byte, out_valid, out_data
    );

    modport slave (
        output start, base_addr, mem_ack, mem_data, dec_done, dec_result, out_ready,
        input  busy, finish, err, mem_req, mem_addr, dec_load, dec_byte, out_valid, out_data
    );
endinterface

// File: rtl/decode_ctrl.sv
// Steganographic decode controller: fetches pixel bytes, feeds them to an
// external LSB extractor in groups of four, takes the first extracted byte as
// a payload length header and streams that many payload bytes to a sink.
module decode_ctrl #(
    parameter int MAX_BYTES = 255,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    decode_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [15:0]   r_addr;
    logic [1:0]    r_grp_cnt;
    logic [7:0]    r_byte_cnt;
    logic [7:0]    r_len;
    logic          r_hdr;
    logic [TW-1:0] r_tmo;
    logic          r_mem_req;
    logic          r_dec_load;
    logic [7:0]    r_dec_byte;
    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic          r_busy;
    logic          r_finish;
    logic          r_err;

    logic [7:0]    w_byte_cnt_inc;
    logic          w_tmo_expired;
    logic          w_len_too_big;

    assign w_byte_cnt_inc = r_byte_cnt + 8'd1;
    // WAIT lasts at most TIMEOUT cycles: counter values 0 .. TIMEOUT-1
    assign w_tmo_expired  = (r_tmo == TW'(TIMEOUT - 1));
    assign w_len_too_big  = (bus.dec_result > 8'(MAX_BYTES));

    // the fetch address is the running pixel pointer, held stable through FETCH
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_addr;
    assign bus.dec_load  = r_dec_load;
    assign bus.dec_byte  = r_dec_byte;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.finish    = r_finish;
    assign bus.err       = r_err;

    // job sequencer: every output is a register set on the transition into its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_grp_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_len       <= '0;
            r_hdr       <= 1'b0;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_dec_load  <= 1'b0;
            r_dec_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // single-cycle strobes
            r_finish   <= 1'b0;
            r_dec_load <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr     <= bus.base_addr;
                        r_grp_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_hdr      <= 1'b1;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (bus.mem_ack) begin
                        r_dec_byte <= bus.mem_data;
                        r_mem_req  <= 1'b0;
                        r_dec_load <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_addr    <= r_addr + 16'd1;
                    r_grp_cnt <= r_grp_cnt + 2'd1;
                    if (r_grp_cnt == 2'd3) begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end

                S_WAIT: begin
                    // a completion in the last allowed cycle wins over the timeout
                    if (bus.dec_done) begin
                        if (r_hdr) begin
                            r_len <= bus.dec_result;
                            r_hdr <= 1'b0;
                            if (bus.dec_result == 8'd0) begin
                                r_finish <= 1'b1;
                                r_state  <= S_DONE;
                            end else if (w_len_too_big) begin
                                r_finish <= 1'b1;
                                r_err    <= 1'b1;
                                r_state  <= S_ERR;
                            end else begin
                                r_mem_req <= 1'b1;
                                r_state   <= S_FETCH;
                            end
                        end else begin
                            r_out_data  <= bus.dec_result;
                            r_out_valid <= 1'b1;
                            r_state     <= S_EMIT;
                        end
                    end else if (w_tmo_expired) begin
                        r_finish <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_byte_cnt  <= w_byte_cnt_inc;
                        if (w_byte_cnt_inc == r_len) begin
                            r_finish <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    // err remains set in IDLE until the next accepted start
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_mem_req   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: the bench plays pixel memory, LSB extractor
// and payload sink; expected payload bytes go into a scoreboard queue when a
// job is launched and are compared as the DUT emits them.
module tb_decode_ctrl;
    localparam int MAXB = 4;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    decode_ctrl_if bus ();

    decode_ctrl #(.MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] pix(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   32'(bus.mem_req),   0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
        check({tag, "_dec_load"},  32'(bus.dec_load),  0);
        check({tag, "_dec_byte"},  32'(bus.dec_byte),  0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_data"},  32'(bus.out_data),  0);
        check({tag, "_busy"},      32'(bus.busy),      0);
        check({tag, "_finish"},    32'(bus.finish),    0);
        check({tag, "_err"},       32'(bus.err),       0);
    endtask

    // One job: header byte hdr, npay payload bytes 0x41.., extractor answers
    // dly cycles into each WAIT, sink stalls 'stall' cycles per byte.
    task automatic run_job(input logic [15:0] base, input logic [7:0] hdr, input int npay,
                           input int stall, input int dly, input bit exp_err,
                           input bit poke_start, input bit abort_emit, input string tag);
        logic [7:0]  dec_q[$];
        logic [15:0] exp_a;
        int loads = 0, cd = -1, stall_cnt = 0, fin_cnt = 0;
        int fin_cyc = -1, last_load = -1, cyc = 0;
        bit done_loop = 1'b0, aborted = 1'b0;

        dec_q.push_back(hdr);
        for (int i = 0; i < npay; i++) begin
            dec_q.push_back(8'h41 + 8'(i));
            if (!exp_err) exp_q.push_back(8'h41 + 8'(i));
        end

        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        while (!done_loop) begin
            @(negedge clk);
            cyc++;
            bus.start = poke_start && (cyc == 3);
            if (bus.start) bus.base_addr = 16'h1234;

            // extractor: answer dly cycles after the group's 4th load
            bus.dec_done = 1'b0;
            if (cd == 0) begin
                bus.dec_done   = 1'b1;
                bus.dec_result = dec_q.pop_front();
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end

            // pixel memory: same-cycle acknowledge
            bus.mem_ack = bus.mem_req;
            exp_a = base + 16'(loads);
            if (bus.mem_req) begin
                bus.mem_data = pix(bus.mem_addr);
                check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(exp_a));
            end
            if (bus.dec_load) begin
                check({tag, "_dec_byte"}, 32'(bus.dec_byte), 32'(pix(exp_a)));
                loads++;
                if (loads % 4 == 0) begin
                    cd = dly;
                    last_load = cyc;
                end
            end

            // sink with per-byte backpressure
            bus.out_ready = 1'b0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_out"}, 32'(bus.out_valid), 0);
                end else begin
                    check({tag, "_out_data"}, 32'(bus.out_data), 32'(exp_q[0]));
                    if (abort_emit && stall_cnt == 2) begin
                        aborted = 1'b1;
                        done_loop = 1'b1;
                    end else if (stall_cnt < stall) begin
                        stall_cnt++;
                    end else begin
                        bus.out_ready = 1'b1;
                        stall_cnt = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end

            if (bus.finish) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = cyc;
                check({tag, "_err_at_finish"}, 32'(bus.err), 32'(exp_err));
            end
            check({tag, "_busy"}, 32'(bus.busy), 32'((fin_cyc < 0) || (cyc == fin_cyc)));
            if (fin_cyc >= 0 && cyc > fin_cyc)
                check({tag, "_err_hold"}, 32'(bus.err), 32'(exp_err));
            if (fin_cyc >= 0 && cyc == fin_cyc + 3) done_loop = 1'b1;
            if (cyc > 1500) begin
                check({tag, "_cycle_budget"}, 32'(cyc), 0);
                done_loop = 1'b1;
            end
        end

        bus.start    = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.dec_done = 1'b0;
        bus.out_ready = 1'b0;
        if (!aborted) begin
            check({tag, "_finish_count"}, 32'(fin_cnt), 1);
            check({tag, "_loads"}, 32'(loads), 32'(4 * (1 + npay)));
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
            if (npay == 0)
                check({tag, "_latency"}, 32'(fin_cyc - last_load),
                      32'((dly >= TMO) ? (TMO + 1) : (dly + 2)));
        end
        $display("job %s: base=%h hdr=%h loads=%0d finish_cycle=%0d err=%0b aborted=%0b",
                 tag, base, hdr, loads, fin_cyc, bus.err, aborted);
    endtask

    initial begin
        bus.start = 1'b0;      bus.base_addr = '0;
        bus.mem_ack = 1'b0;    bus.mem_data = '0;
        bus.dec_done = 1'b0;   bus.dec_result = '0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // normal job, with a start pulse while busy that must be ignored
        run_job(16'h0010, 8'h02, 2, 0, 3, 1'b0, 1'b1, 1'b0, "normal");
        // zero-length header, immediate and last-allowed-cycle completion
        run_job(16'h0100, 8'h00, 0, 0, 0, 1'b0, 1'b0, 1'b0, "zero_len");
        run_job(16'h0180, 8'h00, 0, 0, TMO - 1, 1'b0, 1'b0, 1'b0, "zero_len_late");
        // length above MAX_BYTES, then exactly MAX_BYTES (also clears err)
        run_job(16'h0400, 8'h05, 0, 0, 2, 1'b1, 1'b0, 1'b0, "len_err");
        run_job(16'h0500, 8'h04, 4, 1, 1, 1'b0, 1'b0, 1'b0, "len_max");
        // extractor silent for TIMEOUT cycles; its late answer must be ignored
        run_job(16'h0600, 8'h01, 0, 0, TMO, 1'b1, 1'b0, 1'b0, "timeout");
        // backpressure with an address wrap through 0xFFFF
        run_job(16'hFFFE, 8'h01, 1, 5, 2, 1'b0, 1'b0, 1'b0, "bp_wrap");

        // reset while a payload byte is waiting for the sink
        run_job(16'h0200, 8'h01, 1, 100, 2, 1'b0, 1'b0, 1'b1, "abort_emit");
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid_emit");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_job(16'h0300, 8'h02, 2, 0, 1, 1'b0, 1'b0, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
